// File: rtl/flash_axim_pkg.sv
// flash_axim_pkg: shared definitions for the flash AXI4-Lite master.
//   - request op encodings
//   - flash slave address-bit op encoding positions
//   - FSM state enum
//   - fixed PROT / STRB values
//   - op_addr(): builds the encoded AXI address for a request
package flash_axim_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_ERASE_A = 2'b10,
        OP_ERASE_B = 2'b11
    } op_t;

    localparam int OPBIT_RW  = 24;
    localparam int OPBIT_ERA = 25;
    localparam int OPBIT_ERB = 26;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR_AW,
        ST_WR_B,
        ST_ER_A,
        ST_ER_BUSY,
        ST_ER_DONE,
        ST_RSP
    } state_t;

    localparam logic [2:0] DEF_PROT  = 3'b000;
    localparam logic [3:0] DEF_WSTRB = 4'hF;

    // The flash slave decodes the operation from a single high address bit
    // above the 24-bit byte address.
    function automatic logic [31:0] op_addr(input op_t op, input logic [23:0] addr);
        logic [31:0] a;
        a = {8'h00, addr};
        case (op)
            OP_ERASE_A: a[OPBIT_ERA] = 1'b1;
            OP_ERASE_B: a[OPBIT_ERB] = 1'b1;
            default:    a[OPBIT_RW]  = 1'b1;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/flash_axi_master_if.sv
// flash_axi_master_if: AXI4-Lite bus between the flash master and the flash
// controller slave port.
//   master modport: drives AW/W/AR channels and BREADY/RREADY
//   slave  modport: drives AWREADY/WREADY/ARREADY and the B/R channels
interface flash_axi_master_if;

    logic [31:0] AWADDR;
    logic        AWVALID;
    logic [2:0]  AWPROT;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;

    logic        BVALID;
    logic [1:0]  BRESP;
    logic        BREADY;

    logic [31:0] ARADDR;
    logic        ARVALID;
    logic [2:0]  ARPROT;
    logic        ARREADY;

    logic        RVALID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, AWPROT, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BVALID, BRESP, output BREADY,
        output ARADDR, ARVALID, ARPROT, input ARREADY,
        input RVALID, RDATA, RRESP, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, AWPROT, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BVALID, BRESP, input BREADY,
        input ARADDR, ARVALID, ARPROT, output ARREADY,
        output RVALID, RDATA, RRESP, input RREADY
    );

endinterface

// File: rtl/flash_axim_wait_cnt.sv
// flash_axim_wait_cnt: down-counter measuring how long the FSM has sat in
// its current state.
//   ACLK, ARESET : clock, synchronous active-high reset
//   state        : current FSM state; any change reloads the counter
//   limit        : number of cycles allowed in the current state
//   expired      : high in the limit-th cycle spent in the current state
//
// The state change is seen one cycle late (state vs. its registered copy),
// so the reload value is limit-2 and the reload cycle itself counts as the
// first cycle in the state.
module flash_axim_wait_cnt
    import flash_axim_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  state_t       state,
    input  logic [W-1:0] limit,
    output logic         expired
);

    state_t       st_q;
    logic [W-1:0] cnt;
    logic         load;

    assign load = (state != st_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            st_q <= ST_IDLE;
            cnt  <= '0;
        end else begin
            st_q <= state;
            if (load) begin
                cnt <= (limit > W'(1)) ? (limit - W'(2)) : '0;
            end else if (cnt != '0) begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign expired = load ? (limit <= W'(1)) : (cnt == '0);

endmodule

// File: rtl/flash_axi_master.sv
// flash_axi_master: single-outstanding request interface to AXI4-Lite
// master for the flash controller (read / write / erase-A / erase-B).
//   ACLK, ARESET          : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake; req_op, req_addr, req_wdata
//   rsp_valid             : one-cycle response pulse with rsp_rdata, rsp_err
//   busy                  : a request is in progress
//   axi                   : AXI4-Lite master port (flash_axi_master_if.master)
// Build option: define FLASH_AXIM_TIMEOUT_EN to abort any wait state that
// lasts TIMEOUT_CYCLES with an error response.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | req_ready high, waiting for a request
// ST_RD_A    | ARVALID high until ARREADY
// ST_RD_D    | RREADY high until RVALID, capture data/resp
// ST_WR_AW   | AWVALID and WVALID high, each dropped on its own handshake
// ST_WR_B    | BREADY high until BVALID
// ST_ER_A    | AWVALID high (no W) until AWREADY
// ST_ER_BUSY | wait for AWREADY low (erase started) within the busy window
// ST_ER_DONE | wait for AWREADY high (erase finished)
// ST_RSP     | rsp_valid pulse, then back to idle
module flash_axi_master
    import flash_axim_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 1000000,
    parameter int ERASE_BUSY_WINDOW = 64
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [23:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    flash_axi_master_if.master       axi
);

    localparam logic [31:0] ERASE_LIMIT = 32'(ERASE_BUSY_WINDOW);
    localparam logic [31:0] TMO_LIMIT   = 32'(TIMEOUT_CYCLES);

    state_t      state;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [31:0] cnt_limit;
    logic        cnt_expired;
    logic        aw_hs, w_hs;

    assign axi.AWADDR  = aw_addr;
    assign axi.AWVALID = aw_valid;
    assign axi.AWPROT  = DEF_PROT;
    assign axi.WDATA   = w_data;
    assign axi.WSTRB   = DEF_WSTRB;
    assign axi.WVALID  = w_valid;
    assign axi.BREADY  = b_ready;
    assign axi.ARADDR  = ar_addr;
    assign axi.ARVALID = ar_valid;
    assign axi.ARPROT  = DEF_PROT;
    assign axi.RREADY  = r_ready;

    assign aw_hs = aw_valid & axi.AWREADY;
    assign w_hs  = w_valid & axi.WREADY;

    // One counter serves both the erase busy window and the wait timeout.
    assign cnt_limit = (state == ST_ER_BUSY) ? ERASE_LIMIT : TMO_LIMIT;

    flash_axim_wait_cnt #(.W(32)) u_wait_cnt (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .state   (state),
        .limit   (cnt_limit),
        .expired (cnt_expired)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            aw_valid  <= 1'b0;
            aw_addr   <= '0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            b_ready   <= 1'b0;
            ar_valid  <= 1'b0;
            ar_addr   <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (op_t'(req_op))
                            OP_READ: begin
                                ar_valid <= 1'b1;
                                ar_addr  <= op_addr(op_t'(req_op), req_addr);
                                state    <= ST_RD_A;
                            end
                            OP_WRITE: begin
                                aw_valid <= 1'b1;
                                aw_addr  <= op_addr(op_t'(req_op), req_addr);
                                w_valid  <= 1'b1;
                                w_data   <= req_wdata;
                                state    <= ST_WR_AW;
                            end
                            default: begin
                                aw_valid <= 1'b1;
                                aw_addr  <= op_addr(op_t'(req_op), req_addr);
                                state    <= ST_ER_A;
                            end
                        endcase
                    end
                end
                ST_RD_A: begin
                    if (axi.ARREADY) begin
                        ar_valid <= 1'b0;
                        ar_addr  <= '0;
                        r_ready  <= 1'b1;
                        state    <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (axi.RVALID) begin
                        r_ready   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= axi.RDATA;
                        rsp_err   <= (axi.RRESP != 2'b00);
                        state     <= ST_RSP;
                    end
                end
                ST_WR_AW: begin
                    if (aw_hs) begin
                        aw_valid <= 1'b0;
                        aw_addr  <= '0;
                    end
                    if (w_hs) begin
                        w_valid <= 1'b0;
                    end
                    if ((aw_hs || !aw_valid) && (w_hs || !w_valid)) begin
                        b_ready <= 1'b1;
                        state   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (axi.BVALID) begin
                        b_ready   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= (axi.BRESP != 2'b00);
                        state     <= ST_RSP;
                    end
                end
                ST_ER_A: begin
                    if (axi.AWREADY) begin
                        aw_valid <= 1'b0;
                        aw_addr  <= '0;
                        state    <= ST_ER_BUSY;
                    end
                end
                ST_ER_BUSY: begin
                    // AWREADY dropping is the slave's only sign the erase began.
                    if (!axi.AWREADY) begin
                        state <= ST_ER_DONE;
                    end else if (cnt_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_ER_DONE: begin
                    if (axi.AWREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

`ifdef FLASH_AXIM_TIMEOUT_EN
            // Overrides the case above. ER_BUSY already has its own bound.
            if (state != ST_IDLE && state != ST_RSP && state != ST_ER_BUSY && cnt_expired) begin
                aw_valid  <= 1'b0;
                aw_addr   <= '0;
                w_valid   <= 1'b0;
                b_ready   <= 1'b0;
                ar_valid  <= 1'b0;
                ar_addr   <= '0;
                r_ready   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
                state     <= ST_RSP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_flash_axi_master.sv
module tb_flash_axi_master;
    import flash_axim_pkg::*;

    localparam int TMO = 100;
    localparam int EBW = 64;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic prev_rsp = 1'b0;

    flash_axi_master_if bus();

    flash_axi_master #(.TIMEOUT_CYCLES(TMO), .ERASE_BUSY_WINDOW(EBW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .axi       (bus)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard: every response is popped against the expectation queued
    // when its request was driven.
    always @(negedge ACLK) begin
        if (rsp_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
                    n_bad++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
            n_cmp++;
            if (prev_rsp === 1'b1) begin
                n_bad++;
                $display("FAIL rsp_pulse: rsp_valid high 2 cycles, required 1");
            end
        end
        prev_rsp = rsp_valid;
        n_cmp++;
        if ((bus.ARVALID !== 1'b1 && bus.ARADDR !== 32'h0) || (bus.AWVALID !== 1'b1 && bus.AWADDR !== 32'h0)) begin
            n_bad++;
            $display("FAIL addr_idle_zero: ARADDR=%h AWADDR=%h with valids %b%b, required 0",
                     bus.ARADDR, bus.AWADDR, bus.ARVALID, bus.AWVALID);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for req_ready, presents one request for one cycle and returns at
    // the negedge after acceptance (first cycle of the A state).
    task automatic issue_req(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
        int k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge ACLK);
            k++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL req_ready_wait: req_ready=%b, required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        @(negedge ACLK);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        n_cmp++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, rsp_valid, rsp_err, busy, req_ready} !== 9'b000000001) begin
            n_bad++;
            $display("FAIL reset_ctrl: aw%b w%b b%b ar%b r%b rv%b re%b busy%b rdy%b, required all 0 except req_ready",
                     bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, rsp_valid, rsp_err, busy, req_ready);
        end
        n_cmp++;
        if ({bus.AWADDR, bus.ARADDR, bus.WDATA, rsp_rdata} !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_data: AWADDR=%h ARADDR=%h WDATA=%h rdata=%h, required 0",
                     bus.AWADDR, bus.ARADDR, bus.WDATA, rsp_rdata);
        end
        n_cmp++;
        if ({bus.WSTRB, bus.AWPROT, bus.ARPROT} !== {4'hF, 3'b000, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_const: WSTRB=%h AWPROT=%b ARPROT=%b, required F 000 000",
                     bus.WSTRB, bus.AWPROT, bus.ARPROT);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_read();
        int bad_rdy = 0;
        int bad_b = 0;
        exp_q.push_back(exp_t'({32'hDEADBEEF, 1'b0}));
        issue_req(OP_READ, 24'h000123, 32'h0);
        n_cmp++;
        if (bus.ARVALID !== 1'b1 || bus.ARADDR !== 32'h01000123) begin
            n_bad++;
            $display("FAIL rd_ar: ARVALID=%b ARADDR=%h, required 1 01000123", bus.ARVALID, bus.ARADDR);
        end
        // A competing request held during the read must not be accepted.
        req_valid = 1'b1;
        req_op    = OP_WRITE;
        @(negedge ACLK);
        n_cmp++;
        if (bus.ARVALID !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_ar_hold: ARVALID=%b, required 1", bus.ARVALID);
        end
        bus.ARREADY = 1'b1;
        @(negedge ACLK);
        bus.ARREADY = 1'b0;
        n_cmp++;
        if ({bus.ARVALID, bus.ARADDR, bus.RREADY} !== {1'b0, 32'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL rd_ar_done: ARVALID=%b ARADDR=%h RREADY=%b, required 0 0 1",
                     bus.ARVALID, bus.ARADDR, bus.RREADY);
        end
        bus.BVALID = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            if (req_ready !== 1'b0 || bus.AWVALID !== 1'b0) bad_rdy++;
            if (bus.BREADY !== 1'b0) bad_b++;
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_bad++;
            $display("FAIL rd_no_accept: %0d cycles with req_ready/AWVALID high, required 0", bad_rdy);
        end
        n_cmp++;
        if (bad_b != 0) begin
            n_bad++;
            $display("FAIL rd_bvalid_ignored: BREADY high %0d cycles, required 0", bad_b);
        end
        bus.RVALID = 1'b1;
        bus.RDATA  = 32'hDEADBEEF;
        bus.RRESP  = 2'b00;
        @(negedge ACLK);
        bus.RVALID = 1'b0;
        bus.RDATA  = 32'h0;
        bus.BVALID = 1'b0;
        req_valid  = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || bus.RREADY !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_rsp_time: rsp_valid=%b RREADY=%b, required 1 0", rsp_valid, bus.RREADY);
        end
        @(negedge ACLK);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_idle: rsp_valid=%b req_ready=%b busy=%b, required 0 1 0", rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_write();
        exp_q.push_back(exp_t'({32'h0, 1'b1}));
        issue_req(OP_WRITE, 24'h0000F0, 32'hA5A5A5A5);
        n_cmp++;
        if ({bus.AWVALID, bus.WVALID, bus.AWADDR, bus.WDATA, bus.WSTRB} !== {2'b11, 32'h010000F0, 32'hA5A5A5A5, 4'hF}) begin
            n_bad++;
            $display("FAIL wr_start: AWV=%b WV=%b AWADDR=%h WDATA=%h WSTRB=%h, required 1 1 010000F0 A5A5A5A5 F",
                     bus.AWVALID, bus.WVALID, bus.AWADDR, bus.WDATA, bus.WSTRB);
        end
        bus.AWREADY = 1'b1;
        @(negedge ACLK);
        bus.AWREADY = 1'b0;
        n_cmp++;
        if ({bus.AWVALID, bus.AWADDR, bus.WVALID} !== {1'b0, 32'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL wr_aw_first: AWVALID=%b AWADDR=%h WVALID=%b, required 0 0 1",
                     bus.AWVALID, bus.AWADDR, bus.WVALID);
        end
        bus.RVALID = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if (bus.WVALID !== 1'b1 || bus.RREADY !== 1'b0 || bus.BREADY !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_w_held: WVALID=%b RREADY=%b BREADY=%b, required 1 0 0", bus.WVALID, bus.RREADY, bus.BREADY);
        end
        @(negedge ACLK);
        bus.WREADY = 1'b1;
        @(negedge ACLK);
        bus.WREADY = 1'b0;
        n_cmp++;
        if ({bus.WVALID, bus.BREADY, bus.RREADY} !== 3'b010) begin
            n_bad++;
            $display("FAIL wr_b_phase: WVALID=%b BREADY=%b RREADY=%b, required 0 1 0", bus.WVALID, bus.BREADY, bus.RREADY);
        end
        bus.BVALID = 1'b1;
        bus.BRESP  = 2'b10;
        @(negedge ACLK);
        bus.BVALID = 1'b0;
        bus.BRESP  = 2'b00;
        bus.RVALID = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_rsp_time: rsp_valid=%b, required 1", rsp_valid);
        end
    endtask

    task automatic test_erase_b();
        int early = 0;
        int wv = 0;
        exp_q.push_back(exp_t'({32'h0, 1'b0}));
        bus.AWREADY = 1'b1;
        issue_req(OP_ERASE_B, 24'h010000, 32'h0);
        n_cmp++;
        if ({bus.AWVALID, bus.AWADDR, bus.WVALID} !== {1'b1, 32'h04010000, 1'b0}) begin
            n_bad++;
            $display("FAIL erb_aw: AWVALID=%b AWADDR=%h WVALID=%b, required 1 04010000 0",
                     bus.AWVALID, bus.AWADDR, bus.WVALID);
        end
        @(negedge ACLK);
        n_cmp++;
        if (bus.AWVALID !== 1'b0 || bus.AWADDR !== 32'h0) begin
            n_bad++;
            $display("FAIL erb_aw_done: AWVALID=%b AWADDR=%h, required 0 0", bus.AWVALID, bus.AWADDR);
        end
        repeat (4) @(negedge ACLK);
        bus.AWREADY = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b0) early++;
            if (bus.WVALID !== 1'b0) wv++;
        end
        n_cmp++;
        if (early != 0 || wv != 0) begin
            n_bad++;
            $display("FAIL erb_wait: early rsp %0d, WVALID %0d cycles, required 0 0", early, wv);
        end
        bus.AWREADY = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL erb_rsp_time: rsp_valid=%b, required 1", rsp_valid);
        end
        bus.AWREADY = 1'b0;
    endtask

    task automatic test_erase_a_window();
        int k = 0;
        exp_q.push_back(exp_t'({32'h0, 1'b1}));
        bus.AWREADY = 1'b1;
        issue_req(OP_ERASE_A, 24'h000400, 32'h0);
        n_cmp++;
        if (bus.AWADDR !== 32'h02000400 || bus.WVALID !== 1'b0) begin
            n_bad++;
            $display("FAIL era_aw: AWADDR=%h WVALID=%b, required 02000400 0", bus.AWADDR, bus.WVALID);
        end
        do begin
            @(negedge ACLK);
            k++;
        end while (rsp_valid !== 1'b1 && k < 200);
        n_cmp++;
        if (k != EBW + 1) begin
            n_bad++;
            $display("FAIL era_window: rsp after %0d cycles, required %0d", k, EBW + 1);
        end
        bus.AWREADY = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bus.ARREADY = 1'b1;
        issue_req(OP_READ, 24'h000200, 32'h0);
        @(negedge ACLK);
        bus.ARREADY = 1'b0;
        n_cmp++;
        if (bus.RREADY !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_rd_d: RREADY=%b, required 1", bus.RREADY);
        end
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        n_cmp++;
        if ({bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY, rsp_valid, req_ready, bus.ARADDR} !== {7'b0000001, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_mid: arv%b awv%b wv%b rr%b br%b rv%b rdy%b ARADDR=%h, required 0 0 0 0 0 0 1 0",
                     bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY, rsp_valid, req_ready, bus.ARADDR);
        end
        bus.RVALID = 1'b1;
        bus.RDATA  = 32'h55AA55AA;
        repeat (4) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b0 || bus.RREADY !== 1'b0) seen++;
        end
        bus.RVALID = 1'b0;
        bus.RDATA  = 32'h0;
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_mid_no_rsp: %0d cycles with rsp_valid/RREADY, required 0", seen);
        end
    endtask

`ifdef FLASH_AXIM_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        exp_q.push_back(exp_t'({32'h0, 1'b1}));
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        issue_req(OP_WRITE, 24'h000033, 32'h11223344);
        do begin
            @(negedge ACLK);
            k++;
            bus.AWREADY = 1'b0;
            bus.WREADY  = 1'b0;
        end while (rsp_valid !== 1'b1 && k < 400);
        n_cmp++;
        if (k != TMO + 1 || bus.BREADY !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_write: rsp after %0d cycles BREADY=%b, required %0d 0", k, bus.BREADY, TMO + 1);
        end
        exp_q.push_back(exp_t'({32'h12345678, 1'b0}));
        bus.ARREADY = 1'b1;
        issue_req(OP_READ, 24'h000044, 32'h0);
        @(negedge ACLK);
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b1;
        bus.RDATA   = 32'h12345678;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        bus.RVALID = 1'b0;
        bus.RDATA  = 32'h0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_next_read: rsp_valid=%b, required 1", rsp_valid);
        end
    endtask
`else
    task automatic test_long_wait();
        int early = 0;
        exp_q.push_back(exp_t'({32'h0, 1'b0}));
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        issue_req(OP_WRITE, 24'h000033, 32'h11223344);
        @(negedge ACLK);
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b0 || bus.BREADY !== 1'b1) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL long_wait_hold: %0d cycles left WR_B early, required 0", early);
        end
        bus.BVALID = 1'b1;
        @(negedge ACLK);
        bus.BVALID = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL long_wait_rsp: rsp_valid=%b, required 1", rsp_valid);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [23:0] a;
        logic [31:0] d;
        logic [1:0]  resp;
        logic        is_rd;
        int          k;
        bus.ARREADY = 1'b1;
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            is_rd = 1'($urandom_range(0, 1));
            a     = 24'($urandom);
            d     = $urandom;
            resp  = 2'($urandom_range(0, 3));
            exp_q.push_back(exp_t'({(is_rd ? d : 32'h0), (resp != 2'b00)}));
            issue_req(is_rd ? 2'b00 : 2'b01, a, d);
            n_cmp++;
            if (is_rd ? (bus.ARADDR !== {8'h01, a}) : (bus.AWADDR !== {8'h01, a} || bus.WDATA !== d)) begin
                n_bad++;
                $display("FAIL b2b_addr: rd=%b ARADDR=%h AWADDR=%h WDATA=%h, required addr %h data %h",
                         is_rd, bus.ARADDR, bus.AWADDR, bus.WDATA, {8'h01, a}, d);
            end
            repeat ($urandom_range(0, 3)) @(negedge ACLK);
            if (is_rd) begin
                bus.RVALID = 1'b1;
                bus.RDATA  = d;
                bus.RRESP  = resp;
            end else begin
                bus.BVALID = 1'b1;
                bus.BRESP  = resp;
            end
            k = 0;
            while (rsp_valid !== 1'b1 && k < 20) begin
                @(negedge ACLK);
                k++;
            end
            bus.RVALID = 1'b0;
            bus.BVALID = 1'b0;
            bus.RDATA  = 32'h0;
            n_cmp++;
            if (rsp_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_rsp: rsp_valid=%b after %0d cycles, required 1", rsp_valid, k);
            end
        end
        bus.ARREADY = 1'b0;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
    endtask

    initial begin
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.BRESP   = 2'b00;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RDATA   = 32'h0;
        bus.RRESP   = 2'b00;

        test_reset();
        test_read();
        test_write();
        test_erase_b();
        test_erase_a_window();
        test_reset_mid();
`ifdef FLASH_AXIM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_back_to_back();

        repeat (3) @(negedge ACLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rsp_missing: %0d expected responses never arrived, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_axi_master.md
Name: flash_axi_master

Overview:
- AXI4-Lite master (initiator) that drives the flash controller's AXI4-Lite slave port.
- Turns a simple single-outstanding request interface (read / write / erase) into correctly sequenced AW/W/B or AR/R transactions, including the flash slave's address-bit op encoding.
- Sits between a CPU-side command source (boot loader, DMA, test sequencer) and the flash controller. Returns one response per request.

Parameters:
- TIMEOUT_CYCLES, 1000000, max cycles any wait state may last before abort (used only with FLASH_AXIM_TIMEOUT_EN).
- ERASE_BUSY_WINDOW, 64, cycles after erase AW handshake within which AWREADY must drop (busy seen).

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready
- req_op  in  2  00 read, 01 write, 10 erase-A (AWADDR[25]), 11 erase-B (AWADDR[26])
- req_addr  in  24  flash byte address
- req_wdata  in  32  write word
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data; 0 for non-reads
- rsp_err  out  1  nonzero RESP, or timeout, or erase busy never seen
- busy  out  1  state != IDLE
- AWADDR  out  32;  AWVALID  out  1;  AWPROT  out  3;  AWREADY  in  1
- WDATA  out  32;  WSTRB  out  4;  WVALID  out  1;  WREADY  in  1
- BVALID  in  1;  BRESP  in  2;  BREADY  out  1
- ARADDR  out  32;  ARVALID  out  1;  ARPROT  out  3;  ARREADY  in  1
- RVALID  in  1;  RDATA  in  32;  RRESP  in  2;  RREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs 0; AWADDR, ARADDR, WDATA, rsp_rdata 0; WSTRB 4'hF; AWPROT and ARPROT 3'b000; rsp_valid and rsp_err 0; state IDLE.
- Reset asserted mid-operation aborts at the next edge with no response.
- All outputs are registered.
- req_ready = (state==IDLE). The request is latched on acceptance; AXI valids assert on the next cycle.
- Address encoding: read ARADDR = {7'b0,1'b1,addr}; write AWADDR = {7'b0,1'b1,addr}; erase-A AWADDR = {6'b0,1'b1,1'b0,addr}; erase-B AWADDR = {5'b0,1'b1,2'b0,addr}.
- AWADDR and ARADDR are driven to 0 whenever the corresponding VALID is low. The slave samples address bits as levels, so this is mandatory.
- States and transitions:
  - IDLE: on accept go to RD_A, WR_AW, or ER_A by op.
  - RD_A: ARVALID=1 until ARREADY; then ARVALID=0, ARADDR=0, go to RD_D.
  - RD_D: RREADY=1; on RVALID capture RDATA, set err=(RRESP!=0), go to RSP.
  - WR_AW: AWVALID=1 and WVALID=1 assert together. Each drops independently on its own handshake. Once both are done go to WR_B. AWADDR is held until the AW handshake, then zeroed.
  - WR_B: BREADY=1; on BVALID set err=(BRESP!=0), go to RSP.
  - ER_A: AWVALID=1 (WVALID stays 0) until AWREADY; then zero AWADDR and go to ER_BUSY. The slave gives no B response for erase.
  - ER_BUSY: wait for AWREADY==0, then go to ER_DONE. If not seen within ERASE_BUSY_WINDOW cycles, go to RSP with err=1.
  - ER_DONE: wait for AWREADY==1, then go to RSP with err=0.
  - RSP: rsp_valid=1 for one cycle with rdata/err; next state IDLE (req_ready returns the cycle after).
- Ready already high when valid rises counts as a same-cycle handshake; minimum of one cycle in each A state.
- Unexpected BVALID in a read flow, or RVALID in a write flow: ignore (READY stays low).
- A new request is never accepted while busy; there is one outstanding transaction at most.

Optional Feature:
- FLASH_AXIM_TIMEOUT_EN defined:
  - A cycle counter resets on every state change.
  - If any non-IDLE/RSP state reaches TIMEOUT_CYCLES: all VALID/READY outputs drop, addresses are zeroed, and the FSM goes to RSP with rsp_err=1 and rsp_rdata=0.
- Undefined: no counter; waits are unbounded. ERASE_BUSY_WINDOW still applies.

Decomposition:
- Shared package flash_axim_pkg:
  - op encodings (OP_READ, OP_WRITE, OP_ERASE_A, OP_ERASE_B)
  - address-bit constants (OPBIT_RW=24, OPBIT_ERA=25, OPBIT_ERB=26)
  - state enum
  - default PROT/STRB constants
- One sub-module: flash_axim_wait_cnt. It is a loadable down-counter with clear-on-state-change and an expiry flag, shared by the erase busy window and the optional timeout.

Test Plan:
- Read 0x000123: slave returns RDATA 0xDEADBEEF, RRESP 0 after 40 cycles -> ARADDR 0x01000123 during ARVALID only; rsp_valid 1 cycle after R handshake with rdata 0xDEADBEEF, err 0.
- Write 0x0000F0 data 0xA5A5A5A5: slave has WREADY 3 cycles after AWREADY -> AWVALID drops first, WVALID is held, AWADDR is 0 once AWVALID is low; BRESP 2'b10 -> rsp_err 1.
- Erase-B at 0x010000: AWREADY high, then low 5 cycles later for 200 cycles, then high -> AWADDR 0x04010000 with no WVALID; rsp_valid exactly 1 cycle after AWREADY rises; err 0.
- Erase-A where AWREADY never drops -> rsp_err 1 at ERASE_BUSY_WINDOW+1 cycles after the handshake.
- ARESET asserted in RD_D -> next cycle all valids 0, ARADDR 0, no rsp_valid, req_ready 1.
- With FLASH_AXIM_TIMEOUT_EN and TIMEOUT_CYCLES=100, slave never raises BVALID -> rsp_err 1 after 100 cycles in WR_B, BREADY 0; the next read completes normally.
